// File: rtl/ram_sync_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Define RAM_INIT_CLEAR_EN to build the post-reset zeroing sweep (CLEAR state + counter).
module ram_sync_be #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic [DATA_WIDTH/8-1:0] byteEnable,
  input  logic                    ramWrite,
  input  logic                    ramRead,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic                    readValid,
  output logic                    ready
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("ram_sync_be: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

`ifdef RAM_INIT_CLEAR_EN
  localparam state_e RESET_STATE = ST_CLEAR;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef RAM_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

  logic                  accept_c;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [NUM_LANES-1:0]  mem_be_c;

  // A request is only taken when ready was advertised and reset is not overriding the cycle.
  assign accept_c = ready_q & ~reset;

  // Next-state, write-port steering and read-result logic.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    valid_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = address;
    mem_wdata_c = writeData;
    mem_be_c    = byteEnable;
`ifdef RAM_INIT_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
`ifdef RAM_INIT_CLEAR_EN
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = clr_cnt_q;
        mem_wdata_c = '0;
        mem_be_c    = '1;
        clr_cnt_d   = clr_cnt_q + ADDR_WIDTH'(1);
        if (&clr_cnt_q) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
`endif
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept_c && ramWrite) begin
          mem_we_c = 1'b1;
        end
        // The array is read before the same-edge write lands, giving read-before-write.
        if (accept_c && ramRead) begin
          valid_d = 1'b1;
          rdata_d = mem[address];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and read-path registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
`ifdef RAM_INIT_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
`ifdef RAM_INIT_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // Storage array; contents are never touched by reset directly.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (mem_be_c[i]) begin
          mem[mem_addr_c][i*8 +: 8] <= mem_wdata_c[i*8 +: 8];
        end
      end
    end
  end

  assign readData  = rdata_q;
  assign readValid = valid_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_ram_sync_be.sv
// Scoreboard bench for ram_sync_be; covers both the default build and RAM_INIT_CLEAR_EN.
module tb_ram_sync_be;

`ifdef RAM_INIT_CLEAR_EN
  localparam int unsigned AW = 4;
`else
  localparam int unsigned AW = 8;
`endif
  localparam int unsigned DW    = 64;
  localparam int unsigned NL    = DW / 8;
  localparam int unsigned BADDR = (AW == 8) ? 16 : 10;

  logic          clock;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] writeData;
  logic [NL-1:0] byteEnable;
  logic          ramWrite;
  logic          ramRead;
  logic [DW-1:0] readData;
  logic          readValid;
  logic          ready;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;
  logic [DW-1:0] exp_q[$];

  ram_sync_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .writeData  (writeData),
    .byteEnable (byteEnable),
    .ramWrite   (ramWrite),
    .ramRead    (ramRead),
    .readData   (readData),
    .readValid  (readValid),
    .ready      (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every readValid pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (readValid === 1'b1) begin
      vcount++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got readData %h with no read outstanding", readData);
      end else begin
        chk("read_data", 64'(readData), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int unsigned a, input logic [63:0] d, input logic [7:0] be);
    address    = AW'(a);
    writeData  = DW'(d);
    byteEnable = NL'(be);
    ramWrite   = 1'b1;
    step();
    ramWrite   = 1'b0;
  endtask

  task automatic rd(input int unsigned a, input logic [63:0] e);
    address = AW'(a);
    ramRead = 1'b1;
    exp_q.push_back(DW'(e));
    step();
    ramRead = 1'b0;
  endtask

`ifdef RAM_INIT_CLEAR_EN
  // Counts negedges with ready low; optionally injects one write when the count hits inj_at.
  task automatic count_ready_low(input int inj_at, input int unsigned inj_addr, output int lows);
    lows = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (ready === 1'b1) break;
      lows++;
      if (lows == inj_at) begin
        address    = AW'(inj_addr);
        writeData  = '1;
        byteEnable = '1;
        ramWrite   = 1'b1;
      end else begin
        ramWrite = 1'b0;
      end
    end
    ramWrite = 1'b0;
  endtask
`endif

  logic [63:0] words [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                             64'h5A5A_A5A5_0F0F_F0F0, 64'hCAFE_F00D_1234_5678};

  initial begin
    int lows;
    int v0;
    reset      = 1'b1;
    address    = '0;
    writeData  = '0;
    byteEnable = '0;
    ramWrite   = 1'b0;
    ramRead    = 1'b0;
    step();
    step();
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_valid", 64'(readValid), 64'd0);
    chk("reset_data", 64'(readData), 64'd0);

`ifdef RAM_INIT_CLEAR_EN
    reset = 1'b0;
    count_ready_low(0, 0, lows);
    chk("clear_ready_low_cycles", 64'(lows), 64'd16);
    v0 = vcount;
    for (int i = 0; i < 16; i++) rd(i, 64'h0);
    step();
    chk("clear_read_valid_count", 64'(vcount - v0), 64'd16);
`else
    reset = 1'b0;
    step();
    chk("ready_after_release", 64'(ready), 64'd1);
`endif

    // Byte-lane writes, including an all-zero mask and a sparse mask.
    wr(BADDR, 64'h1122_3344_5566_7788, 8'hFF);
    wr(BADDR, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    rd(BADDR, 64'h1122_3344_AAAA_AAAA);
    wr(BADDR, 64'h0, 8'h00);
    rd(BADDR, 64'h1122_3344_AAAA_AAAA);
    wr(BADDR, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81);
    rd(BADDR, 64'hFF22_3344_AAAA_AAFF);

    // Read-before-write on the same address in one cycle.
    wr(5, 64'h1, 8'hFF);
    address    = AW'(5);
    writeData  = DW'(64'h2);
    byteEnable = '1;
    ramWrite   = 1'b1;
    ramRead    = 1'b1;
    exp_q.push_back(DW'(64'h1));
    step();
    ramWrite   = 1'b0;
    ramRead    = 1'b0;
    rd(5, 64'h2);

    // Back-to-back reads, then the last word must be held.
    for (int i = 0; i < 4; i++) wr(i, words[i], 8'hFF);
    v0 = vcount;
    for (int i = 0; i < 4; i++) rd(i, words[i]);
    step();
    step();
    chk("stream_valid_count", 64'(vcount - v0), 64'd4);
    chk("hold_valid_low", 64'(readValid), 64'd0);
    chk("hold_data", 64'(readData), words[3]);

`ifdef RAM_INIT_CLEAR_EN
    // Reset in the middle of the sweep restarts it; writes during the sweep are dropped.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        address    = AW'(2);
        writeData  = '1;
        byteEnable = '1;
        ramWrite   = 1'b1;
      end else begin
        ramWrite = 1'b0;
      end
      step();
    end
    ramWrite = 1'b0;
    chk("midclear_ready_low", 64'(ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_ready_low(6, 1, lows);
    chk("midclear_ready_low_cycles", 64'(lows), 64'd16);
    rd(2, 64'h0);
    rd(1, 64'h0);
    rd(3, 64'h0);
`else
    // Contents survive reset; requests during reset are ignored.
    wr(3, 64'hDEAD_BEEF, 8'hFF);
    reset      = 1'b1;
    address    = AW'(5);
    writeData  = DW'(64'h77);
    byteEnable = '1;
    ramWrite   = 1'b1;
    ramRead    = 1'b1;
    step();
    ramWrite   = 1'b0;
    ramRead    = 1'b0;
    chk("reset2_ready", 64'(ready), 64'd0);
    chk("reset2_valid", 64'(readValid), 64'd0);
    chk("reset2_data", 64'(readData), 64'd0);
    reset = 1'b0;
    step();
    chk("reset2_ready_release", 64'(ready), 64'd1);
    rd(3, 64'hDEAD_BEEF);
    rd(5, 64'h2);
`endif

    step();
    step();
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
